// File: rtl/hd63701_biram_arbiter.sv
// HD63701 built-in RAM arbiter: CPU first, loader (A) and monitor (B) round-robin.
// Optional macro RAMARB_STEAL_EN adds wait counters and a one-cycle CPU stall.
module hd63701_biram_arbiter #(
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic        mcu_clx2,
  input  logic        mcu_rst,
  input  logic [15:0] cpu_ad,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_do,
  output logic        cpu_hold,
  output logic [6:0]  ram_ad,
  output logic        ram_we,
  output logic [7:0]  ram_wd,
  input  logic [7:0]  ram_rd,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [6:0]  a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [6:0]  b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata
);

  if (WAIT_MAX < 1 || WAIT_MAX > (2**WAIT_W) - 1) begin : g_bad_cfg
    $error("WAIT_MAX does not fit in WAIT_W bits");
  end

  logic       cpu_own;
  logic       a_elig, b_elig;
  logic       a_gnt, b_gnt;
  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic       a_rd_q, a_rd_d;
  logic       b_rd_q, b_rd_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;
  logic       ptr_q, ptr_d;
  logic [6:0] ram_ad_q, ram_ad_d;

  // Ownership and grant: CPU wins its cycle, requester in ack cycle is masked
  always_comb begin
    cpu_own = (cpu_ad[15:7] == 9'b0_0000_0001) && !cpu_hold;
    a_elig  = a_req && !a_ack_q;
    b_elig  = b_req && !b_ack_q;
    a_gnt   = !cpu_own && a_elig && (!b_elig || !ptr_q);
    b_gnt   = !cpu_own && b_elig && !a_gnt;
  end

  // RAM port mux; address holds when nobody drives it
  always_comb begin
    ram_ad_d = ram_ad_q;
    ram_we   = 1'b0;
    ram_wd   = 8'h00;
    unique case (1'b1)
      cpu_own: begin
        ram_ad_d = cpu_ad[6:0];
        ram_we   = cpu_wr;
        ram_wd   = cpu_do;
      end
      a_gnt: begin
        ram_ad_d = a_addr;
        ram_we   = a_we;
        ram_wd   = a_wdata;
      end
      b_gnt: begin
        ram_ad_d = b_addr;
        ram_we   = b_we;
        ram_wd   = b_wdata;
      end
      default: ;
    endcase
    if (mcu_rst) ram_we = 1'b0;
  end

  assign ram_ad = ram_ad_d;

  // Completion pulse, read-data capture and round-robin pointer
  always_comb begin
    a_ack_d   = a_gnt;
    b_ack_d   = b_gnt;
    a_rd_d    = a_gnt && !a_we;
    b_rd_d    = b_gnt && !b_we;
    a_rdata_d = (a_ack_q && a_rd_q) ? ram_rd : a_rdata_q;
    b_rdata_d = (b_ack_q && b_rd_q) ? ram_rd : b_rdata_q;
    ptr_d     = ptr_q;
    if (a_gnt) ptr_d = 1'b1;
    else if (b_gnt) ptr_d = 1'b0;
  end

  // Arbiter state registers
  always_ff @(posedge mcu_clx2) begin
    if (mcu_rst) begin
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rd_q    <= 1'b0;
      b_rd_q    <= 1'b0;
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
      ptr_q     <= 1'b0;
    end else begin
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rd_q    <= a_rd_d;
      b_rd_q    <= b_rd_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      ptr_q     <= ptr_d;
    end
  end

  // Last RAM address, only meaningful as an idle-cycle hold value
  always_ff @(posedge mcu_clx2) begin
    ram_ad_q <= ram_ad_d;
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_d;
  assign b_rdata = b_rdata_d;

`ifdef RAMARB_STEAL_EN
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_STEAL  = 1'b1
  } state_e;

  localparam logic [WAIT_W-1:0] WaitLim = WAIT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] a_wait_q, a_wait_d;
  logic [WAIT_W-1:0] b_wait_q, b_wait_d;

  assign cpu_hold = (state_q == ST_STEAL);

  // Saturating wait counters; cleared on issue or abort
  always_comb begin
    a_wait_d = a_wait_q;
    b_wait_d = b_wait_q;
    if (!a_req || a_gnt) a_wait_d = '0;
    else if (a_wait_q != WaitLim) a_wait_d = a_wait_q + 1'b1;
    if (!b_req || b_gnt) b_wait_d = '0;
    else if (b_wait_q != WaitLim) b_wait_d = b_wait_q + 1'b1;
  end

  // One STEAL cycle when a counter saturates, never two in a row
  always_comb begin
    state_d = ST_NORMAL;
    if (state_q == ST_NORMAL &&
        (a_wait_d == WaitLim || b_wait_d == WaitLim))
      state_d = ST_STEAL;
  end

  // Steal FSM and counter registers
  always_ff @(posedge mcu_clx2) begin
    if (mcu_rst) begin
      state_q  <= ST_NORMAL;
      a_wait_q <= '0;
      b_wait_q <= '0;
    end else begin
      state_q  <= state_d;
      a_wait_q <= a_wait_d;
      b_wait_q <= b_wait_d;
    end
  end
`else
  assign cpu_hold = 1'b0;
`endif

endmodule
